matmul_load_seq: RTL and testbench

- Sequencer that fills the 2x2 A operand registers and 2x3 B operand registers of the matrix-multiply datapath through the 1-to-12 operand demux.
- Accepts two independent 16-bit valid/ready word streams, one for A (row-major) and one for B (row-major).
- Drives the demux select codes and data inputs one word per stream per cycle.
- Pulses mult_start once every operand has landed in the demux registers.

---
 rtl/matmul_load_seq.sv | 144 ++++++++++++++
 tb/tb_matmul_load_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_load_seq.sv
// rtl/matmul_load_seq.sv - operand load sequencer feeding the 1-to-12 demux of the 2x2 by 2x3 matmul
//
// Takes two independent valid/ready word streams (A row-major, B row-major)
// and steers each accepted word onto the demux with its register index.
// Once every A and B word has been presented, a single mult_start pulse is
// issued to kick off the multiply.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 one-cycle load request, only honoured in IDLE
//   a_valid/a_data/a_ready  A operand stream
//   b_valid/b_data/b_ready  B operand stream
//   sel1/dmx_data1        demux A select (3'b110 = no write) and data
//   sel2/dmx_data2        demux B select (3'b110 = no write) and data
//   busy                  high while loading or flushing
//   mult_start            one-cycle pulse after the last operand is written

module matmul_load_seq #(
    parameter int A_COUNT = 4,
    parameter int B_COUNT = 6,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic [2:0]    sel1,
    output logic [2:0]    sel2,
    output logic [DW-1:0] dmx_data1,
    output logic [DW-1:0] dmx_data2,
    output logic          busy,
    output logic          mult_start
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [2:0] SEL_IDLE = 3'b110;
    localparam logic [2:0] A_FULL   = 3'(A_COUNT);
    localparam logic [2:0] B_FULL   = 3'(B_COUNT);

    state_t          state, state_n;
    logic [2:0]      a_cnt, a_cnt_n;
    logic [2:0]      b_cnt, b_cnt_n;
    logic [2:0]      sel1_n, sel2_n;
    logic [DW-1:0]   dmx_data1_n, dmx_data2_n;
    logic            a_ready_n, b_ready_n, busy_n, mult_start_n;
    logic            a_acc, b_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_cnt      <= 3'd0;
            b_cnt      <= 3'd0;
            sel1       <= SEL_IDLE;
            sel2       <= SEL_IDLE;
            dmx_data1  <= '0;
            dmx_data2  <= '0;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
            busy       <= 1'b0;
            mult_start <= 1'b0;
        end else begin
            state      <= state_n;
            a_cnt      <= a_cnt_n;
            b_cnt      <= b_cnt_n;
            sel1       <= sel1_n;
            sel2       <= sel2_n;
            dmx_data1  <= dmx_data1_n;
            dmx_data2  <= dmx_data2_n;
            a_ready    <= a_ready_n;
            b_ready    <= b_ready_n;
            busy       <= busy_n;
            mult_start <= mult_start_n;
        end
    end

    always_comb begin
        state_n      = state;
        a_cnt_n      = a_cnt;
        b_cnt_n      = b_cnt;
        sel1_n       = SEL_IDLE;
        sel2_n       = SEL_IDLE;
        dmx_data1_n  = dmx_data1;
        dmx_data2_n  = dmx_data2;
        a_ready_n    = 1'b0;
        b_ready_n    = 1'b0;
        busy_n       = 1'b0;
        mult_start_n = 1'b0;

        // The registered readies are only ever high in LOAD with room left,
        // so they double as the "counter below full" qualifier.
        a_acc = (state == LOAD) && a_valid && a_ready;
        b_acc = (state == LOAD) && b_valid && b_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD;
                    a_cnt_n   = 3'd0;
                    b_cnt_n   = 3'd0;
                    a_ready_n = 1'b1;
                    b_ready_n = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            LOAD: begin
                busy_n = 1'b1;
                if (a_acc) begin
                    sel1_n      = a_cnt;
                    dmx_data1_n = a_data;
                    a_cnt_n     = a_cnt + 3'd1;
                end
                if (b_acc) begin
                    sel2_n      = b_cnt;
                    dmx_data2_n = b_data;
                    b_cnt_n     = b_cnt + 3'd1;
                end
                if (a_cnt_n == A_FULL && b_cnt_n == B_FULL) begin
                    state_n = FLUSH;
                end else begin
                    a_ready_n = (a_cnt_n < A_FULL);
                    b_ready_n = (b_cnt_n < B_FULL);
                end
            end
            FLUSH: begin
                // Last word(s) are on the demux this cycle; pulse next cycle.
                state_n      = DONE;
                mult_start_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_load_seq.sv
// tb/tb_matmul_load_seq.sv - scoreboard bench for matmul_load_seq

module tb_matmul_load_seq;

    localparam int A_N = 4;
    localparam int B_N = 6;
    localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst, start, a_valid, b_valid;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, busy, mult_start;
    logic [2:0]  sel1, sel2;
    logic [15:0] dmx_data1, dmx_data2;

    logic        start1, a_valid1, b_valid1;
    logic [15:0] a_data1, b_data1;
    logic        a_ready1, b_ready1, busy1, mult_start1;
    logic [2:0]  sel1_1, sel2_1;
    logic [15:0] dmx_data1_1, dmx_data2_1;

    always #5 clk = ~clk;

    matmul_load_seq #(.A_COUNT(A_N), .B_COUNT(B_N), .DW(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel1(sel1), .sel2(sel2), .dmx_data1(dmx_data1), .dmx_data2(dmx_data2),
        .busy(busy), .mult_start(mult_start)
    );

    matmul_load_seq #(.A_COUNT(1), .B_COUNT(1), .DW(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_valid(a_valid1), .a_data(a_data1), .a_ready(a_ready1),
        .b_valid(b_valid1), .b_data(b_data1), .b_ready(b_ready1),
        .sel1(sel1_1), .sel2(sel2_1), .dmx_data1(dmx_data1_1), .dmx_data2(dmx_data2_1),
        .busy(busy1), .mult_start(mult_start1)
    );

    int checks = 0;
    int errors = 0;

    int          m_state = M_IDLE;
    int          m_acnt = 0, m_bcnt = 0;
    int          cyc = 0, last_acc = 0, ms_seen = 0;
    logic [15:0] a_base, b_base;
    logic [18:0] qa[$];
    logic [18:0] qb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle(input logic av, input logic bv, input logic st, input logic rs);
        logic [18:0] e;
        logic        acc_a, acc_b;
        rst     = rs;
        start   = st;
        a_valid = av;
        b_valid = bv;
        a_data  = av ? a_base + 16'(m_acnt) : 16'($urandom);
        b_data  = bv ? b_base + 16'(m_bcnt) : 16'($urandom);
        @(negedge clk);
        check("a_ready", 32'(a_ready), 32'(m_state == M_LOAD && m_acnt < A_N));
        check("b_ready", 32'(b_ready), 32'(m_state == M_LOAD && m_bcnt < B_N));
        check("busy", 32'(busy), 32'(m_state == M_LOAD || m_state == M_FLUSH));
        check("mult_start", 32'(mult_start), 32'(m_state == M_DONE));
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("sel1", 32'(sel1), 32'(e[18:16]));
            check("dmx_data1", 32'(dmx_data1), 32'(e[15:0]));
        end else begin
            check("sel1_idle", 32'(sel1), 32'h6);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("sel2", 32'(sel2), 32'(e[18:16]));
            check("dmx_data2", 32'(dmx_data2), 32'(e[15:0]));
        end else begin
            check("sel2_idle", 32'(sel2), 32'h6);
        end
        check("sel1_legal", 32'(sel1[2] == 1'b0 || sel1 == 3'b110), 32'h1);
        check("sel2_legal", 32'(sel2 != 3'b111), 32'h1);
        if (mult_start === 1'b1) begin
            ms_seen++;
            check("ms_latency", 32'(cyc - last_acc), 32'd2);
        end
        // Reference update for the coming posedge
        if (rs) begin
            m_state = M_IDLE;
            m_acnt  = 0;
            m_bcnt  = 0;
            qa.delete();
            qb.delete();
        end else begin
            case (m_state)
                M_IDLE: if (st) begin
                    m_state = M_LOAD;
                    m_acnt  = 0;
                    m_bcnt  = 0;
                end
                M_LOAD: begin
                    acc_a = av && (m_acnt < A_N);
                    acc_b = bv && (m_bcnt < B_N);
                    if (acc_a) begin
                        qa.push_back({3'(m_acnt), a_data});
                        m_acnt++;
                    end
                    if (acc_b) begin
                        qb.push_back({3'(m_bcnt), b_data});
                        m_bcnt++;
                    end
                    if (acc_a || acc_b) last_acc = cyc;
                    if (m_acnt == A_N && m_bcnt == B_N) m_state = M_FLUSH;
                end
                M_FLUSH: m_state = M_DONE;
                default: m_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: both continuous; 1: A toggles; 2: start pulsed in LOAD and DONE; 3: random valids
    task automatic run_load(input int mode);
        int   n;
        logic av, bv, st;
        n = 0;
        ms_seen = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        while (m_state != M_IDLE && n < 200) begin
            av = 1'b1;
            bv = 1'b1;
            st = 1'b0;
            case (mode)
                1: av = n[0];
                2: st = (n == 2) || (m_state == M_DONE);
                3: begin
                    av = 1'($urandom_range(0, 1));
                    bv = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            cycle(av, bv, st, 1'b0);
            n++;
        end
        check("load_completes", 32'(m_state == M_IDLE), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("ms_count", 32'(ms_seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        start1 = 1'b0; a_valid1 = 1'b0; b_valid1 = 1'b0; a_data1 = '0; b_data1 = '0;
        a_base = 16'h0001; b_base = 16'h0011;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dmx_data1", 32'(dmx_data1), 32'h0);
        check("rst_dmx_data2", 32'(dmx_data2), 32'h0);
        check("rst_sels", 32'({sel1, sel2}), 32'({3'b110, 3'b110}));
        check("rst_flags", 32'({a_ready, b_ready, busy, mult_start}), 32'h0);

        run_load(0);
        a_base = 16'h0100; b_base = 16'h0200;
        run_load(1);
        a_base = 16'h1000; b_base = 16'h2000;
        run_load(2);

        // reset after 2 A and 3 B accepts
        a_base = 16'h0A00; b_base = 16'h0B00;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_dmx_data1", 32'(dmx_data1), 32'h0);
        check("mid_rst_dmx_data2", 32'(dmx_data2), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        a_base = 16'h0C00; b_base = 16'h0D00;
        run_load(0);

        for (int i = 0; i < 3; i++) begin
            a_base = 16'($urandom);
            b_base = 16'($urandom);
            run_load(3);
        end

        // A_COUNT=1, B_COUNT=1 instance
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; a_valid1 = 1'b1; b_valid1 = 1'b1;
        a_data1 = 16'hA5A5; b_data1 = 16'h5A5A;
        @(negedge clk);
        check("u1_load", 32'({a_ready1, b_ready1, busy1, mult_start1}), 32'hE);
        @(posedge clk); #1;
        a_valid1 = 1'b0; b_valid1 = 1'b0;
        @(negedge clk);
        check("u1_flush_sels", 32'({sel1_1, sel2_1}), 32'h0);
        check("u1_flush_data", {dmx_data1_1, dmx_data2_1}, 32'hA5A55A5A);
        check("u1_flush_flags", 32'({a_ready1, b_ready1, busy1, mult_start1}), 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        check("u1_done_flags", 32'({busy1, mult_start1}), 32'h1);
        check("u1_done_sels", 32'({sel1_1, sel2_1}), 32'({3'b110, 3'b110}));
        @(posedge clk); #1;
        @(negedge clk);
        check("u1_idle_flags", 32'({a_ready1, b_ready1, busy1, mult_start1}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
